code_loader: RTL

Program loader feeding the code storage write port. Accepts a framed byte stream over a valid/ready handshake and checks a length header and XOR checksum. Assembles little-endian code words and issues one write per word at consecutive lines starting at 0. Holds the core (storage fetch pointer) in reset while loading and releases it with `core_active` only after a frame passes its checksum.

---
 rtl/code_loader_pkg.sv | 18 +
 rtl/code_loader_if.sv | 32 +++
 rtl/code_loader.sv | 114 +++++++++++
 3 files changed

// File: rtl/code_loader_pkg.sv
// Shared types and constants for the program loader: FSM states and frame field widths.
package code_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_W_LO,
        S_W_HI,
        S_CKSUM,
        S_DONE,
        S_ERROR
    } loader_state_t;

    localparam int BYTES_PER_WORD = 2;
    localparam int LEN_W          = 16;

endpackage

// File: rtl/code_loader_if.sv
// Byte-stream input and code-storage write port of the loader, bundled with modports.
interface code_loader_if #(
    parameter int CODE_SIZE = 12
);
    // Stream handshake: a byte moves on a clk edge where in_valid & in_ready are both 1;
    // the source holds in_data stable while in_valid is 1 and in_ready is 0, and
    // in_ready never depends combinationally on in_valid.
    logic [7:0]           in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic                 write_en;
    logic [31:0]          write_line;
    logic [CODE_SIZE-1:0] write_data;

    modport master (
        input  in_data,
        input  in_valid,
        output in_ready,
        output write_en,
        output write_line,
        output write_data
    );

    modport slave (
        output in_data,
        output in_valid,
        input  in_ready,
        input  write_en,
        input  write_line,
        input  write_data
    );
endinterface

// File: rtl/code_loader.sv
// Framed program loader: length header, little-endian word assembly, XOR checksum,
// and core reset/active control that releases the core only after a verified frame.
module code_loader
    import code_loader_pkg::*;
#(
    parameter int CODE_SIZE     = 12,
    parameter int MAX_CODE_LINE = 100
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    code_loader_if.master       bus,
    output logic                core_reset,
    output logic                core_active,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [31:0]         words_loaded,
    output loader_state_t       state_dbg
);

    localparam int               HI_BITS = CODE_SIZE - 8 * (BYTES_PER_WORD - 1);
    localparam logic [LEN_W-1:0] CAP     = LEN_W'(MAX_CODE_LINE + 1);

    loader_state_t    state, state_nx;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] len_full;
    logic [7:0]       xor_acc;
    logic [7:0]       low_byte;
    logic [31:0]      idx;
    logic             accept;
    logic             start_ok;
    logic             word_last;

    assign bus.in_ready = (state == S_LEN_LO) || (state == S_LEN_HI) || (state == S_W_LO) ||
                          (state == S_W_HI)   || (state == S_CKSUM);
    assign busy        = bus.in_ready;
    assign done        = (state == S_DONE);
    assign error       = (state == S_ERROR);
    assign core_active = (state == S_DONE);
    assign core_reset  = (state != S_DONE);
    assign state_dbg   = state;

    assign accept    = bus.in_valid & bus.in_ready;
    assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
    assign len_full  = {bus.in_data, len[7:0]};
    assign word_last = ((idx + 32'd1) == {{(32 - LEN_W){1'b0}}, len});

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: if (start) state_nx = S_LEN_LO;
            S_LEN_LO: if (accept) state_nx = S_LEN_HI;
            S_LEN_HI: begin
                if (accept) begin
                    if (len_full == '0)      state_nx = S_CKSUM;
                    else if (len_full > CAP) state_nx = S_ERROR;
                    else                     state_nx = S_W_LO;
                end
            end
            S_W_LO: if (accept) state_nx = S_W_HI;
            S_W_HI: if (accept) state_nx = word_last ? S_CKSUM : S_W_LO;
            S_CKSUM: if (accept) state_nx = (bus.in_data == xor_acc) ? S_DONE : S_ERROR;
            default: state_nx = S_IDLE;
        endcase
    end

    // Datapath: running XOR covers every frame byte; the checksum byte's own update is harmless
    // because the accumulator is cleared on the next start.
    always_ff @(posedge clk) begin
        if (reset) begin
            len            <= '0;
            xor_acc        <= '0;
            low_byte       <= '0;
            idx            <= '0;
            words_loaded   <= '0;
            bus.write_en   <= 1'b0;
            bus.write_line <= '0;
            bus.write_data <= '0;
        end else begin
            bus.write_en <= 1'b0;
            if (start_ok) begin
                xor_acc      <= '0;
                idx          <= '0;
                words_loaded <= '0;
            end
            if (accept) begin
                xor_acc <= xor_acc ^ bus.in_data;
                case (state)
                    S_LEN_LO: len[7:0]  <= bus.in_data;
                    S_LEN_HI: len[15:8] <= bus.in_data;
                    S_W_LO:   low_byte  <= bus.in_data;
                    S_W_HI: begin
                        bus.write_en   <= 1'b1;
                        bus.write_line <= idx;
                        bus.write_data <= {bus.in_data[HI_BITS-1:0], low_byte};
                        idx            <= idx + 32'd1;
                        words_loaded   <= words_loaded + 32'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
